// File: rtl/note_sequencer.sv
// Song ROM walker: fetches (note, duration) entries, times each note with a
// tempo-scaled unit counter and drives the tone generator; handles pause, song switch and speed.
module note_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned NOTE_W     = 5,
    parameter int unsigned DUR_W      = 3,
    parameter int unsigned BASE_TICKS = 6250000,
    parameter int unsigned SONG1_BASE = 0,
    parameter int unsigned SONG2_BASE = 128,
    parameter int unsigned SONG_SPAN  = 128,
    parameter bit          LOOP       = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    song_en,
    input  logic                    play_en,
    input  logic                    ctl,
    input  logic                    speed_up,
    input  logic                    speed_dn,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_vld,
    output logic                    paused,
    output logic                    song_done,
    output logic [1:0]              speed_lvl
);

    localparam int unsigned CNT_W = (BASE_TICKS > 1) ? $clog2(BASE_TICKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DUR_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic                vld_q, vld_d;
    logic                paused_q, paused_d;
    logic                done_q, done_d;
    logic [1:0]          speed_q, speed_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                song_en_q;

    logic [NOTE_W-1:0]   rom_note_c;
    logic [DUR_W-1:0]    rom_dur_c;
    logic [CNT_W-1:0]    reload_c;
    logic [ADDR_W-1:0]   base_c;

    assign rom_note_c = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur_c  = rom_data[DUR_W-1:0];
    assign reload_c   = CNT_W'((BASE_TICKS >> speed_q) - 1);
    assign base_c     = song_en ? ADDR_W'(SONG1_BASE) : ADDR_W'(SONG2_BASE);

    // Speed level: saturating, simultaneous pulses cancel.
    always_comb begin
        speed_d = speed_q;
        if (speed_up && !speed_dn && speed_q != 2'd3) begin
            speed_d = speed_q + 2'd1;
        end else if (speed_dn && !speed_up && speed_q != 2'd0) begin
            speed_d = speed_q - 2'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        note_d   = note_q;
        vld_d    = vld_q;
        paused_d = paused_q;
        done_d   = 1'b0;

        if (!play_en) begin
            state_d  = S_IDLE;
            idx_d    = '0;
            rem_d    = '0;
            cnt_d    = '0;
            vld_d    = 1'b0;
            paused_d = 1'b0;
        end else if (song_en != song_en_q && state_q != S_IDLE) begin
            state_d  = S_FETCH;
            idx_d    = '0;
            rem_d    = '0;
            cnt_d    = '0;
            paused_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    vld_d    = 1'b0;
                    idx_d    = '0;
                    paused_d = 1'b0;
                    state_d  = S_FETCH;
                end
                S_FETCH: state_d = S_LOAD;
                S_LOAD: begin
                    // A zero duration or running off the song span ends the song.
                    if (rom_dur_c == '0 || idx_q == ADDR_W'(SONG_SPAN)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        vld_d   = 1'b0;
                    end else begin
                        note_d  = rom_note_c;
                        rem_d   = rom_dur_c;
                        cnt_d   = reload_c;
                        vld_d   = 1'b1;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (ctl) begin
                        vld_d    = 1'b1;
                        paused_d = 1'b0;
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else if (rem_q > DUR_W'(1)) begin
                            rem_d = rem_q - DUR_W'(1);
                            cnt_d = reload_c;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        vld_d    = 1'b0;
                        paused_d = 1'b1;
                    end
                end
                S_DONE: begin
                    vld_d = 1'b0;
                    if (LOOP) begin
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        rom_addr_d = base_c + idx_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            note_q     <= '0;
            vld_q      <= 1'b0;
            paused_q   <= 1'b0;
            done_q     <= 1'b0;
            speed_q    <= 2'd0;
            rom_addr_q <= ADDR_W'(SONG1_BASE);
            song_en_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            note_q     <= note_d;
            vld_q      <= vld_d;
            paused_q   <= paused_d;
            done_q     <= done_d;
            speed_q    <= speed_d;
            rom_addr_q <= rom_addr_d;
            song_en_q  <= song_en;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign note      = note_q;
    assign note_vld  = vld_q;
    assign paused    = paused_q;
    assign song_done = done_q;
    assign speed_lvl = speed_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (LOOP=0 / LOOP=1) with BASE_TICKS=8; a monitor
// measures each visible note run and song_done pulse and checks them against a queue.
module tb_note_sequencer;

    logic       clk;
    logic       rst_n, song_en, ctl, speed_up, speed_dn;
    logic       play_w[2];
    logic [7:0] rom_addr_w[2];
    logic [7:0] rom_data_w[2];
    logic [4:0] note_w[2];
    logic       vld_w[2], pau_w[2], done_w[2];
    logic [1:0] spd_w[2];

    typedef struct {
        int dut;
        int kind;
        int note;
        int vis;
        int pau;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  done_cnt[2];
    int  run_note[2], run_vis[2], run_pau[2];
    bit  run_act[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    note_sequencer #(.BASE_TICKS(8), .LOOP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .song_en(song_en), .play_en(play_w[0]), .ctl(ctl),
        .speed_up(speed_up), .speed_dn(speed_dn), .rom_addr(rom_addr_w[0]),
        .rom_data(rom_data_w[0]), .note(note_w[0]), .note_vld(vld_w[0]),
        .paused(pau_w[0]), .song_done(done_w[0]), .speed_lvl(spd_w[0])
    );

    note_sequencer #(.BASE_TICKS(8), .LOOP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .song_en(song_en), .play_en(play_w[1]), .ctl(ctl),
        .speed_up(speed_up), .speed_dn(speed_dn), .rom_addr(rom_addr_w[1]),
        .rom_data(rom_data_w[1]), .note(note_w[1]), .note_vld(vld_w[1]),
        .paused(pau_w[1]), .song_done(done_w[1]), .speed_lvl(spd_w[1])
    );

    // Song 1: (5,2) (9,1) end; song 2 at 128: (3,1) end. End markers carry junk notes.
    function automatic logic [7:0] rom_f(input logic [7:0] a);
        case (a)
            8'd0:    return {5'd5, 3'd2};
            8'd1:    return {5'd9, 3'd1};
            8'd2:    return {5'd31, 3'd0};
            8'd128:  return {5'd3, 3'd1};
            8'd129:  return {5'd17, 3'd0};
            default: return 8'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        rom_data_w[0] <= rom_f(rom_addr_w[0]);
        rom_data_w[1] <= rom_f(rom_addr_w[1]);
    end

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_note(input int d, input int n, input int v, input int p);
        ev_t e;
        e.dut = d; e.kind = 0; e.note = n; e.vis = v; e.pau = p;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int d);
        ev_t e;
        e.dut = d; e.kind = 1; e.note = 0; e.vis = 0; e.pau = 0;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input int d, input int kind, input int n, input int v, input int p);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: dut %0d kind %0d note %0d vis %0d pau %0d",
                     d, kind, n, v, p);
        end else begin
            e = exp_q.pop_front();
            check_eq("ev_dut", d, e.dut);
            check_eq("ev_kind", kind, e.kind);
            if (kind == 0) begin
                check_eq("ev_note", n, e.note);
                check_eq("ev_visible_cycles", v, e.vis);
                check_eq("ev_paused_cycles", p, e.pau);
            end
        end
    endtask

    // Monitor: a run spans the visible cycles of one note, bridging pauses.
    initial begin
        for (int d = 0; d < 2; d++) begin
            done_cnt[d] = 0;
            run_act[d]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (run_act[d] && (vld_w[d] ? (int'(note_w[d]) != run_note[d]) : !pau_w[d])) begin
                    pop_check(d, 0, run_note[d], run_vis[d], run_pau[d]);
                    run_act[d] = 1'b0;
                end
                if (vld_w[d] && !run_act[d]) begin
                    run_act[d]  = 1'b1;
                    run_note[d] = int'(note_w[d]);
                    run_vis[d]  = 0;
                    run_pau[d]  = 0;
                end
                if (run_act[d]) begin
                    if (vld_w[d]) run_vis[d]++;
                    else if (pau_w[d]) run_pau[d]++;
                end
                if (done_w[d]) begin
                    done_cnt[d]++;
                    pop_check(d, 1, 0, 0, 0);
                end
            end
        end
    end

    task automatic wait_done(input int d, input string name);
        int i;
        i = 0;
        while (!done_w[d] && i < 300) begin
            tick(1);
            i++;
        end
        check_eq(name, int'(done_w[d]), 1);
    endtask

    task automatic pulse(input logic u, input logic dn, input int exp_lvl, input string name);
        speed_up = u;
        speed_dn = dn;
        tick(1);
        speed_up = 1'b0;
        speed_dn = 1'b0;
        check_eq(name, int'(spd_w[0]), exp_lvl);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far",
                 passes, checks);
        $fatal(1);
    end

    initial begin
        int lat;
        rst_n = 1'b0; song_en = 1'b1; ctl = 1'b1; speed_up = 1'b0; speed_dn = 1'b0;
        play_w[0] = 1'b1; play_w[1] = 1'b0;

        // Reset held with play_en high.
        tick(2);
        check_eq("rst_note_vld", int'(vld_w[0]), 0);
        check_eq("rst_speed_lvl", int'(spd_w[0]), 0);
        check_eq("rst_rom_addr", int'(rom_addr_w[0]), 0);
        check_eq("rst_note", int'(note_w[0]), 0);
        check_eq("rst_paused", int'(pau_w[0]), 0);
        check_eq("rst_song_done", int'(done_w[0]), 0);

        // Song 1 plain playback.
        push_note(0, 5, 18, 0);
        push_note(0, 9, 10, 0);
        push_done(0);
        rst_n = 1'b1;
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!vld_w[0] && lat < 10);
        check_eq("first_note_latency", lat, 3);
        check_eq("first_note_code", int'(note_w[0]), 5);
        wait_done(0, "song1_done_wait");
        tick(1);
        check_eq("song_done_one_cycle", int'(done_w[0]), 0);
        check_eq("done_note_vld", int'(vld_w[0]), 0);
        tick(5);
        check_eq("no_loop_single_done", done_cnt[0], 1);
        play_w[0] = 1'b0;
        tick(2);

        // Pause for 20 cycles after 5 visible cycles of note 5.
        push_note(0, 5, 18, 20);
        push_note(0, 9, 10, 0);
        push_done(0);
        play_w[0] = 1'b1;
        tick(7);
        ctl = 1'b0;
        tick(10);
        check_eq("pause_note_vld", int'(vld_w[0]), 0);
        check_eq("pause_paused", int'(pau_w[0]), 1);
        tick(10);
        ctl = 1'b1;
        tick(1);
        check_eq("resume_paused", int'(pau_w[0]), 0);
        check_eq("resume_note_vld", int'(vld_w[0]), 1);
        wait_done(0, "pause_done_wait");
        play_w[0] = 1'b0;
        tick(2);

        // Speed level 2 (P=2), then saturation and cancel cases during DONE.
        pulse(1'b1, 1'b0, 1, "speed_up_1");
        pulse(1'b1, 1'b0, 2, "speed_up_2");
        push_note(0, 5, 6, 0);
        push_note(0, 9, 4, 0);
        push_done(0);
        play_w[0] = 1'b1;
        wait_done(0, "speed_done_wait");
        tick(1);
        pulse(1'b1, 1'b0, 3, "speed_up_3");
        pulse(1'b1, 1'b0, 3, "speed_sat_hi");
        pulse(1'b1, 1'b1, 3, "speed_both_at3");
        pulse(1'b0, 1'b1, 2, "speed_dn_2");
        pulse(1'b1, 1'b1, 2, "speed_both_at2");
        pulse(1'b0, 1'b1, 1, "speed_dn_1");
        pulse(1'b0, 1'b1, 0, "speed_dn_0");
        pulse(1'b0, 1'b1, 0, "speed_sat_lo");
        play_w[0] = 1'b0;
        tick(2);

        // Switch to song 2 during note 5.
        push_note(0, 5, 6, 0);
        push_note(0, 3, 10, 0);
        push_done(0);
        play_w[0] = 1'b1;
        tick(6);
        song_en = 1'b0;
        tick(1);
        check_eq("switch_rom_addr", int'(rom_addr_w[0]), 128);
        wait_done(0, "switch_done_wait");
        play_w[0] = 1'b0;
        song_en = 1'b1;
        tick(2);

        // LOOP=1 instance: restart after end marker, then stop mid-note.
        push_note(1, 5, 18, 0);
        push_note(1, 9, 10, 0);
        push_done(1);
        push_note(1, 5, 5, 0);
        play_w[1] = 1'b1;
        wait_done(1, "loop_done_wait");
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (!vld_w[1] && lat < 10);
        check_eq("loop_restart_latency", lat, 3);
        check_eq("loop_restart_note", int'(note_w[1]), 5);
        tick(4);
        play_w[1] = 1'b0;
        tick(1);
        check_eq("stop_note_vld", int'(vld_w[1]), 0);
        check_eq("stop_rom_addr", int'(rom_addr_w[1]), 0);
        tick(20);
        check_eq("stop_no_more_done", done_cnt[1], 1);

        // Reset mid-note with speed 1 and song_en low.
        pulse(1'b1, 1'b0, 1, "speed_before_rst");
        push_note(0, 5, 4, 0);
        play_w[0] = 1'b1;
        tick(6);
        rst_n = 1'b0;
        song_en = 1'b0;
        tick(1);
        check_eq("midrst_note_vld", int'(vld_w[0]), 0);
        check_eq("midrst_note", int'(note_w[0]), 0);
        check_eq("midrst_speed_lvl", int'(spd_w[0]), 0);
        check_eq("midrst_rom_addr", int'(rom_addr_w[0]), 0);
        rst_n = 1'b1;
        play_w[0] = 1'b0;
        song_en = 1'b1;
        tick(3);
        check_eq("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
